// File: rtl/inv_shift_row_stage.sv
// rtl/inv_shift_row_stage.sv - column-serial InvShiftRows stage with registered 128-bit output.
// Three column beats are staged in an assembly register; the fourth beat completes and permutes the block.
module inv_shift_row_stage #(
  parameter int DATA_WIDTH = 128,
  parameter int COL_WIDTH  = DATA_WIDTH / 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  invShiftRow_col_valid_in,
  input  logic [COL_WIDTH-1:0]  invShiftRow_col_in,
  output logic                  invShiftRow_col_ready_out,
  input  logic                  invShiftRow_flush_in,
  output logic [DATA_WIDTH-1:0] invShiftRow_data_out,
  output logic                  invShiftRow_valid_out,
  input  logic                  invShiftRow_ready_in,
  output logic                  invShiftRow_busy_out
);

  localparam int ASM_WIDTH = DATA_WIDTH - COL_WIDTH;

  logic [1:0]            cnt_q, cnt_d;
  logic [ASM_WIDTH-1:0]  asm_q, asm_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  accept;

  // Byte b(r+4c) of the result comes from row r, column (c-r) mod 4 of the input.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
    return o;
  endfunction

  assign invShiftRow_col_ready_out = !invShiftRow_flush_in &&
                                     ((cnt_q != 2'd3) || !valid_q || invShiftRow_ready_in);
  assign accept               = invShiftRow_col_valid_in && invShiftRow_col_ready_out;
  assign invShiftRow_data_out  = data_q;
  assign invShiftRow_valid_out = valid_q;
  assign invShiftRow_busy_out  = (cnt_q != 2'd0);

  always_comb begin
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && invShiftRow_ready_in) begin
      valid_d = 1'b0;
    end
    if (invShiftRow_flush_in) begin
      cnt_d = 2'd0;
    end else if (accept) begin
      if (cnt_q == 2'd3) begin
        // A completing beat overrides the drain above so back-to-back blocks keep valid high.
        data_d  = inv_shift_rows({asm_q, invShiftRow_col_in});
        valid_d = 1'b1;
        cnt_d   = 2'd0;
      end else begin
        case (cnt_q)
          2'd0:    asm_d[95:64] = invShiftRow_col_in;
          2'd1:    asm_d[63:32] = invShiftRow_col_in;
          default: asm_d[31:0]  = invShiftRow_col_in;
        endcase
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= 2'd0;
      asm_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_inv_shift_row_stage.sv
// tb/tb_inv_shift_row_stage.sv - scoreboard bench for inv_shift_row_stage.
// Stimulus pushes expected blocks into a queue; a forked monitor pops them as the DUT hands them off.
module tb_inv_shift_row_stage;

  logic         clk;
  logic         reset;
  logic         col_valid;
  logic [31:0]  col;
  logic         col_ready;
  logic         flush;
  logic [127:0] data_out;
  logic         valid_out;
  logic         ready_in;
  logic         busy;

  int checks;
  int errors;
  int stall_cnt;
  int stream_mode;
  int last_pop;
  int cyc;
  logic [127:0] exp_q[$];

  inv_shift_row_stage dut (
    .clk                       (clk),
    .reset                     (reset),
    .invShiftRow_col_valid_in  (col_valid),
    .invShiftRow_col_in        (col),
    .invShiftRow_col_ready_out (col_ready),
    .invShiftRow_flush_in      (flush),
    .invShiftRow_data_out      (data_out),
    .invShiftRow_valid_out     (valid_out),
    .invShiftRow_ready_in      (ready_in),
    .invShiftRow_busy_out      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Encryption-side ShiftRows: row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic         hold;
    logic [127:0] hold_data;
    hold = 1'b0;
    hold_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        hold = 1'b0;
      end else begin
        if (hold && valid_out) chk("hold_stable", data_out, hold_data);
        if (valid_out && ready_in) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual=%h required=none", data_out);
          end else begin
            chk("block_data", data_out, exp_q.pop_front());
            if (stream_mode != 0) begin
              if (last_pop >= 0) chk("stream_period", 128'(cyc - last_pop), 128'd4);
              last_pop = cyc;
            end
          end
        end
        hold = valid_out && !ready_in;
        hold_data = data_out;
      end
    end
  endtask

  task automatic send_beat(input logic [31:0] c);
    logic done;
    done = 1'b0;
    col_valid = 1'b1;
    col = c;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (col_ready) done = 1'b1;
      else stall_cnt++;
      @(posedge clk);
      #1;
    end
    col_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout actual=not_accepted required=accepted");
    end
  endtask

  task automatic send_block(input logic [127:0] beats, input logic [127:0] exp);
    exp_q.push_back(exp);
    send_beat(beats[127:96]);
    send_beat(beats[95:64]);
    send_beat(beats[63:32]);
    send_beat(beats[31:0]);
  endtask

  task automatic send_plain(input logic [127:0] x);
    send_block(shift_rows(x), x);
  endtask

  initial begin
    logic [127:0] x;
    logic [127:0] blk_a;
    checks = 0;
    errors = 0;
    stall_cnt = 0;
    stream_mode = 0;
    last_pop = -1;
    cyc = 0;
    reset = 1'b1;
    col_valid = 1'b0;
    col = '0;
    flush = 1'b0;
    ready_in = 1'b1;
    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    #1;
    chk("reset_data", data_out, '0);
    chk("reset_valid", 128'(valid_out), 128'd0);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_ready", 128'(col_ready), 128'd1);
    reset = 1'b0;

    // Basic permutation vector
    send_block(128'h00010203_04050607_08090A0B_0C0D0E0F,
               128'h000D0A07_04010E0B_0805020F_0C090603);
    chk("latency_valid", 128'(valid_out), 128'd1);
    @(posedge clk);
    #1;
    chk("valid_one_cycle", 128'(valid_out), 128'd0);

    // Round trip through shiftRow
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      send_plain(x);
    end
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: two blocks while ready_in is low
    ready_in = 1'b0;
    send_plain(128'h11223344_55667788_99AABBCC_DDEEFF00);
    x = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
    exp_q.push_back(x);
    send_beat(shift_rows(x)[127:96]);
    send_beat(shift_rows(x)[95:64]);
    send_beat(shift_rows(x)[63:32]);
    col_valid = 1'b1;
    col = shift_rows(x)[31:0];
    repeat (3) begin
      @(negedge clk);
      chk("beat3_blocked", 128'(col_ready), 128'd0);
      @(posedge clk);
      #1;
    end
    ready_in = 1'b1;
    @(negedge clk);
    chk("beat3_drain_ready", 128'(col_ready), 128'd1);
    @(posedge clk);
    #1;
    col_valid = 1'b0;
    chk("valid_continuous", 128'(valid_out), 128'd1);
    @(posedge clk);
    #1;

    // Flush mid-block with a pending output block
    ready_in = 1'b0;
    blk_a = 128'hCAFEBABE_DEADBEEF_01234567_89ABCDEF;
    send_plain(blk_a);
    send_beat(32'h12345678);
    send_beat(32'h9ABCDEF0);
    flush = 1'b1;
    col_valid = 1'b1;
    col = 32'hFFFFFFFF;
    @(negedge clk);
    chk("flush_ready_low", 128'(col_ready), 128'd0);
    chk("busy_before_flush", 128'(busy), 128'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    col_valid = 1'b0;
    @(negedge clk);
    chk("busy_after_flush", 128'(busy), 128'd0);
    chk("pending_valid", 128'(valid_out), 128'd1);
    chk("pending_data", data_out, blk_a);
    @(posedge clk);
    #1;
    ready_in = 1'b1;
    send_plain(128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0);
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-operation with a pending block
    ready_in = 1'b0;
    send_plain(128'h55555555_AAAAAAAA_33333333_CCCCCCCC);
    send_beat(32'h01010101);
    send_beat(32'h02020202);
    send_beat(32'h03030303);
    reset = 1'b1;
    #1;
    chk("midreset_data", data_out, '0);
    chk("midreset_valid", 128'(valid_out), 128'd0);
    chk("midreset_busy", 128'(busy), 128'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    ready_in = 1'b1;
    send_plain(128'h13579BDF_2468ACE0_FEDCBA98_76543210);
    repeat (2) @(posedge clk);
    #1;

    // Sustained stream
    stream_mode = 1;
    last_pop = -1;
    stall_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      send_plain(x);
    end
    chk("stream_stalls", 128'(stall_cnt), 128'd0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("queue_drained", 128'(exp_q.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_shift_row_stage.md
# inv_shift_row_stage

Registered InvShiftRows stage for the AES decryption datapath. It accepts the 128-bit state as four 32-bit column beats and applies the inverse byte permutation of the encryption-side shiftRow step. It presents the result as one full 128-bit block with a valid/ready handshake. It sits between the column-serial key/state feed and the InvSubBytes stage of the inverse round pipeline.

## Interface
- DATA_WIDTH, 128, state width; fixed at 128.
- COL_WIDTH, 32, column beat width; fixed at DATA_WIDTH/4.

- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- invShiftRow_col_valid_in  input  1  column beat valid.
- invShiftRow_col_in  input  32  column beat; column 0 first; bits [31:24] = row 0 byte.
- invShiftRow_col_ready_out  output  1  stage accepts the column beat this cycle.
- invShiftRow_flush_in  input  1  synchronous abort of a partially assembled block.
- invShiftRow_data_out  output  128  InvShiftRows result; [127:120] = byte b0.
- invShiftRow_valid_out  output  1  data_out holds a valid block.
- invShiftRow_ready_in  input  1  downstream accepts the block.
- invShiftRow_busy_out  output  1  high while a block is partially assembled (beat count != 0).

## Operation
- Byte numbering: b0..b15, column-major. Byte bk sits at bits [127-8k : 120-8k]. Byte b(r+4c) is row r, column c.
- Permutation: out b(r+4c) = in b(r+4((c−r) mod 4)). Row 0 is unshifted. Rows 1/2/3 rotate right by 1/2/3 columns. Applying this permutation to the output of shiftRow returns the original state.
- Beat counter cnt, 2 bits, values 0..3. Beats are accepted when col_valid_in && col_ready_out.
- Beats at cnt 0, 1 and 2 are stored into a 96-bit assembly register at column slot cnt, and cnt increments.
- The beat at cnt 3 is concatenated with the assembly register. The permuted 128-bit result loads data_out, valid_out sets, and cnt wraps to 0.
- Ready rule: col_ready_out = !flush_in && (cnt != 3 || !valid_out || ready_in).
  - Beats 0–2 are always accepted.
  - Beat 3 is accepted only if the output slot is empty or is being drained in the same cycle.
- Output handshake:
  - valid_out && ready_in clears valid_out, unless a beat-3 load happens in the same cycle. In that case valid_out stays 1 and data_out takes the new block.
  - data_out and valid_out are held stable while valid_out && !ready_in.
- Flush: cnt→0. The assembly contents are don't-care. While flush is high, ready is low, so a simultaneous beat is dropped and not accepted. Flush does not touch data_out or valid_out; a pending output block survives.
- busy_out = (cnt != 0).
- Reset (async, any state, including mid-block):
  - cnt = 0 and assembly register = 0.
  - data_out = 0, valid_out = 0, busy_out = 0.
  - col_ready_out = 1 once flush is low.

## Timing
- Latency: the block is visible on data_out/valid_out in the cycle after the beat-3 acceptance edge.
- Throughput: one block per 4 cycles sustained, with no bubbles when ready_in is held high.
- col_ready_out is combinational from cnt, valid_out, ready_in and flush_in. No other combinational input-to-output path exists.
- Reset deassertion is synchronous to clk externally. The first beat can be accepted on the first edge after reset deassertion.

## Test plan
- Basic permutation: beats 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F with ready_in=1 -> one cycle after beat 3, data_out = 0x000D0A07_04010E0B_0805020F_0C090603, valid_out=1 for 1 cycle.
- Round trip: random 128-bit X passed through the shiftRow function, then split into beats -> data_out == X, for 1000 random vectors.
- Backpressure:
  - Two back-to-back blocks with ready_in=0 -> block 1 held stable.
  - Beat 3 of block 2 sees col_ready_out=0 until ready_in=1.
  - Block 2 is then loaded with valid_out continuously 1, and no block is lost or duplicated.
- Flush mid-block:
  - After 2 beats, assert flush for 1 cycle together with a valid beat -> beat not accepted, busy_out=0.
  - Then 4 fresh beats produce the correct block.
  - A pending valid_out block is unaffected.
- Reset mid-operation: assert reset after beat 2 with valid_out=1 -> immediately data_out=0, valid_out=0, busy_out=0. After release, a full block produces the correct result.
- Sustained stream: 16 blocks with ready_in=1 and col_valid_in=1 -> 16 outputs at a 4-cycle period, col_ready_out never low.
